// File: rtl/score_bcd_display.sv
// Score-to-BCD converter (serial double-dabble) with a double-buffered digit display
// and a registered per-pixel cell lookup for a VGA overlay.
module score_bcd_display #(
   parameter int NUM_DIGITS    = 4,
   parameter int SCORE_WIDTH   = 16,
   parameter int SIGNED_MODE   = 0,
   parameter int BLANK_LEADING = 1,
   parameter int TOP_LEFT_X    = 100,
   parameter int TOP_LEFT_Y    = 50,
   parameter int DIGIT_W       = 16,
   parameter int DIGIT_H       = 32,
   parameter int X_GAP         = 4
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   startOfFrame,
   input  logic [SCORE_WIDTH-1:0] score,
   input  logic [10:0]            pixelX,
   input  logic [10:0]            pixelY,
   output logic                   digitDR,
   output logic [3:0]             digitValue,
   output logic                   signDR,
   output logic [10:0]            offsetX,
   output logic [10:0]            offsetY,
   output logic                   overflow,
   output logic                   busy
);

   localparam int PITCH       = DIGIT_W + X_GAP;
   localparam int CONV_DIGITS = (SCORE_WIDTH * 31) / 100 + 1;
   // One spare digit above the displayed ones so the overflow test always has a slice to OR.
   localparam int BCD_D       = ((CONV_DIGITS > NUM_DIGITS) ? CONV_DIGITS : NUM_DIGITS) + 1;
   localparam int BCD_W       = BCD_D * 4;
   localparam int SH_W        = BCD_W + SCORE_WIDTH;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CONVERT = 2'd1;
   localparam logic [1:0] S_COMMIT  = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [SH_W-1:0]        sh_q, sh_d, sh_adj;
   logic                   neg_q, neg_d;
   logic [3:0]             disp_q [NUM_DIGITS];
   logic [3:0]             disp_d [NUM_DIGITS];
   logic                   disp_neg_q, disp_neg_d;
   logic                   ovf_q, ovf_d;

   logic                   score_neg;
   logic [SCORE_WIDTH-1:0] mag;

   assign score_neg = (SIGNED_MODE != 0) && score[SCORE_WIDTH-1];
   assign mag       = score_neg ? (~score) + SCORE_WIDTH'(1) : score;

   always_comb begin
      sh_adj = sh_q;
      for (int i = 0; i < BCD_D; i++) begin
         if (sh_q[SCORE_WIDTH + 4*i +: 4] >= 4'd5)
            sh_adj[SCORE_WIDTH + 4*i +: 4] = sh_q[SCORE_WIDTH + 4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      logic hi_nz;
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      neg_d      = neg_q;
      disp_d     = disp_q;
      disp_neg_d = disp_neg_q;
      ovf_d      = ovf_q;
      hi_nz      = |sh_q[SH_W-1 : SCORE_WIDTH + NUM_DIGITS*4];
      case (state_q)
         S_IDLE: begin
            if (startOfFrame) begin
               state_d = S_CONVERT;
               cnt_d   = '0;
               sh_d    = {{BCD_W{1'b0}}, mag};
               neg_d   = score_neg;
            end
         end
         S_CONVERT: begin
            sh_d  = sh_adj << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(SCORE_WIDTH - 1))
               state_d = S_COMMIT;
         end
         S_COMMIT: begin
            state_d    = S_IDLE;
            ovf_d      = hi_nz;
            disp_neg_d = neg_q;
            for (int k = 0; k < NUM_DIGITS; k++)
               disp_d[k] = hi_nz ? 4'd9 : sh_q[SCORE_WIDTH + 4*(NUM_DIGITS-1-k) +: 4];
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sh_q       <= '0;
         neg_q      <= 1'b0;
         disp_neg_q <= 1'b0;
         ovf_q      <= 1'b0;
         for (int k = 0; k < NUM_DIGITS; k++)
            disp_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         neg_q      <= neg_d;
         disp_neg_q <= disp_neg_d;
         ovf_q      <= ovf_d;
         disp_q     <= disp_d;
      end
   end

   // Pixel lookup: cell 0 is the most significant digit, the sign cell sits one pitch left of it.
   int          px, py;
   logic        dr_q, dr_d, sgn_q, sgn_d;
   logic [3:0]  val_q, val_d;
   logic [10:0] ox_q, ox_d, oy_q, oy_d;

   assign px = {21'd0, pixelX};
   assign py = {21'd0, pixelY};

   always_comb begin
      logic seen;
      logic in_y;
      int   left;
      dr_d  = 1'b0;
      val_d = '0;
      sgn_d = 1'b0;
      ox_d  = '0;
      oy_d  = '0;
      seen  = 1'b0;
      left  = 0;
      in_y  = (py >= TOP_LEFT_Y) && (py < TOP_LEFT_Y + DIGIT_H);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         seen = seen | (disp_q[k] != 4'd0);
         left = TOP_LEFT_X + k * PITCH;
         if (in_y && (px >= left) && (px < left + DIGIT_W)) begin
            dr_d  = (BLANK_LEADING == 0) || seen || (k == NUM_DIGITS - 1);
            val_d = disp_q[k];
            ox_d  = 11'(px - left);
            oy_d  = 11'(py - TOP_LEFT_Y);
         end
      end
      if ((SIGNED_MODE != 0) && in_y && (px >= TOP_LEFT_X - PITCH) &&
          (px < TOP_LEFT_X - PITCH + DIGIT_W)) begin
         sgn_d = disp_neg_q;
         ox_d  = 11'(px - (TOP_LEFT_X - PITCH));
         oy_d  = 11'(py - TOP_LEFT_Y);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         dr_q  <= 1'b0;
         val_q <= '0;
         sgn_q <= 1'b0;
         ox_q  <= '0;
         oy_q  <= '0;
      end else begin
         dr_q  <= dr_d;
         val_q <= val_d;
         sgn_q <= sgn_d;
         ox_q  <= ox_d;
         oy_q  <= oy_d;
      end
   end

   assign digitDR    = dr_q;
   assign digitValue = val_q;
   assign signDR     = sgn_q;
   assign offsetX    = ox_q;
   assign offsetY    = oy_q;
   assign overflow   = ovf_q;
   assign busy       = (state_q != S_IDLE);

endmodule
